// File: rtl/tree_node_mux.sv
// Round-robin N:1 packet merge node with a registered output stage.
// Optional per-channel packet counters are built when TREE_NODE_MUX_STATS_EN is defined.
module tree_node_mux #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 32,
  parameter int SRC_W  = $clog2(NUM_CH),
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SRC_W-1:0]         out_src,
  input  logic                     out_ready,
  output logic                     busy,
  input  logic [SRC_W-1:0]         stat_sel,
  output logic [CNT_W-1:0]         stat_cnt
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   grant_q;
  logic [SRC_W-1:0]   ptr_q;
  logic [SRC_W-1:0]   pick;
  logic [SRC_W-1:0]   ptr_next;
  logic               found;
  logic               accept;
  logic               beat_last;
  logic [DATA_W-1:0]  beat_data;

  // Scan requests starting at the round-robin pointer, wrapping past NUM_CH-1.
  always_comb begin
    int               idx;
    logic [SRC_W-1:0] idx_w;
    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_w = SRC_W'(idx);
      if (!found && in_valid[idx_w]) begin
        found = 1'b1;
        pick  = idx_w;
      end
    end
  end

  assign beat_data = in_data[int'(grant_q)*DATA_W +: DATA_W];
  assign beat_last = in_last[grant_q];
  assign ptr_next  = (grant_q == SRC_W'(NUM_CH-1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    in_ready = '0;
    accept   = 1'b0;
    busy     = (state_q == LOCK);
    case (state_q)
      IDLE: begin
        if (found) state_d = LOCK;
      end
      LOCK: begin
        // Only the granted child may advance, and only when the output slot frees up.
        in_ready[grant_q] = !out_valid || out_ready;
        accept            = in_valid[grant_q] && in_ready[grant_q];
        if (accept && beat_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) grant_q <= pick;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= beat_data;
        out_last  <= beat_last;
        out_src   <= grant_q;
        if (beat_last) ptr_q <= ptr_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef TREE_NODE_MUX_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];

  always_ff @(posedge clk) begin
    // NOTE: the counter array is a handful of flops, so it is reset explicitly rather than left to software.
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else if (accept && beat_last && cnt_q[grant_q] != '1) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
    end
  end

  assign stat_cnt = (int'(stat_sel) < NUM_CH) ? cnt_q[stat_sel] : '0;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_tree_node_mux.sv
// Directed bench for tree_node_mux: reset, latency, packet lock, backpressure,
// pointer wrap, round-robin fairness and saturating packet counters.
module tb_tree_node_mux;

  localparam int NUM_CH = 5;
  localparam int DATA_W = 32;
  localparam int SRC_W  = 3;
  localparam int CNT_W  = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [SRC_W-1:0]         out_src;
  logic                     out_ready;
  logic                     busy;
  logic [SRC_W-1:0]         stat_sel;
  logic [CNT_W-1:0]         stat_cnt;

  tree_node_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .busy(busy), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [2:0]  src;
    int          cyc;
  } beat_t;

  beat_t obs_q[$];
  int    cyc       = 0;
  int    n_checks  = 0;
  int    n_errors  = 0;
  int    stall_bad = 0;
  int    hold_bad  = 0;
  int    stalls    = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] data_prev  = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Upstream monitor: a beat transfers on the next rising edge when valid && ready now.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) obs_q.push_back('{out_data, out_last, out_src, cyc});
      if (out_valid && !out_ready) begin
        stalls++;
        if (in_ready != '0) stall_bad++;
      end
      if (stall_prev && out_data !== data_prev) hold_bad++;
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = '0;
    in_last  = '0;
    tick();
    tick();
    rst = 1'b0;
    obs_q.delete();
  endtask

  // Presents n beats on channel ch, holding each beat until it is accepted.
  task automatic send_pkt(input int ch, input int n, input logic [31:0] base, input logic do_last);
    logic acc;
    int   budget;
    for (int b = 0; b < n; b++) begin
      in_data[ch*DATA_W +: DATA_W] = base + b;
      in_last[ch]  = do_last && (b == n - 1);
      in_valid[ch] = 1'b1;
      budget = 0;
      acc    = 1'b0;
      while (!acc && budget < 200) begin
        @(negedge clk);
        acc = in_ready[ch];
        tick();
        budget++;
      end
      if (!acc) begin
        check($sformatf("accept_timeout_ch%0d", ch), acc, 1'b1);
        b = n;
      end
    end
    in_valid[ch] = 1'b0;
    in_last[ch]  = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_data [4];
    logic        exp_last [4];
    logic [2:0]  exp_src  [4];
    logic        done;

    in_data   = '0;
    out_ready = 1'b1;
    stat_sel  = '0;
    do_reset();

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_src", out_src, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);

    // Reset mid-packet, then fresh request from ch3 with 2-cycle latency
    send_pkt(1, 2, 32'hD0, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    obs_q.delete();
    in_data[3*DATA_W +: DATA_W] = 32'h3C;
    in_last[3]  = 1'b1;
    in_valid[3] = 1'b1;
    tick();
    check("lat_e1_out_valid", out_valid, 0);
    check("lat_e1_busy", busy, 1);
    check("lat_e1_in_ready", in_ready, 5'b01000);
    tick();
    check("lat_e2_out_valid", out_valid, 1);
    check("lat_e2_out_src", out_src, 3);
    check("lat_e2_out_data", out_data, 32'h3C);
    check("lat_e2_out_last", out_last, 1);
    in_valid[3] = 1'b0;
    in_last[3]  = 1'b0;
    tick();
    check("lat_e3_busy", busy, 0);
    check("lat_e3_out_valid", out_valid, 0);

    // Packet lock: ch2 holds the grant for 3 beats while ch0 waits
    do_reset();
    fork
      send_pkt(2, 3, 32'hA0, 1'b1);
      begin
        tick();
        send_pkt(0, 1, 32'hB0, 1'b1);
      end
    join
    tick();
    tick();
    exp_data = '{32'hA0, 32'hA1, 32'hA2, 32'hB0};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_src  = '{3'd2, 3'd2, 3'd2, 3'd0};
    check("lock_beats", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      check($sformatf("lock_data%0d", i), obs_q[i].data, exp_data[i]);
      check($sformatf("lock_last%0d", i), obs_q[i].last, exp_last[i]);
      check($sformatf("lock_src%0d", i), obs_q[i].src, exp_src[i]);
    end

    // Backpressure: out_ready pattern 1,0,0 during a 4-beat packet from ch4
    do_reset();
    stalls    = 0;
    stall_bad = 0;
    hold_bad  = 0;
    done      = 1'b0;
    fork
      begin
        send_pkt(4, 4, 32'hC0, 1'b1);
        done = 1'b1;
      end
      begin
        for (int k = 0; k < 100 && !done; k++) begin
          out_ready = (k % 3 == 0);
          tick();
        end
      end
    join
    out_ready = 1'b1;
    tick();
    tick();
    check("bp_beats", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      check($sformatf("bp_data%0d", i), obs_q[i].data, 32'hC0 + i);
      check($sformatf("bp_src%0d", i), obs_q[i].src, 4);
      check($sformatf("bp_last%0d", i), obs_q[i].last, i == 3);
    end
    check("bp_stall_seen", stalls > 0, 1);
    check("bp_in_ready_during_stall", stall_bad, 0);
    check("bp_data_held_during_stall", hold_bad, 0);

    // Wrap: move ptr to 4, then ch0 and ch3 request with ch4 idle
    do_reset();
    send_pkt(3, 1, 32'h30, 1'b1);
    tick();
    obs_q.delete();
    fork
      send_pkt(0, 1, 32'h01, 1'b1);
      send_pkt(3, 1, 32'h33, 1'b1);
    join
    tick();
    tick();
    check("wrap_beats", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      check("wrap_first_src", obs_q[0].src, 0);
      check("wrap_second_src", obs_q[1].src, 3);
    end

    // Fairness: all channels request 1-beat packets continuously
    do_reset();
    for (int c = 0; c < NUM_CH; c++) in_data[c*DATA_W +: DATA_W] = 32'hF0 + c;
    in_last  = '1;
    in_valid = '1;
    for (int k = 0; k < 60 && obs_q.size() < 10; k++) tick();
    in_valid = '0;
    in_last  = '0;
    check("fair_beats", obs_q.size() >= 10, 1);
    for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
      check($sformatf("fair_src%0d", i), obs_q[i].src, i % NUM_CH);
      check($sformatf("fair_data%0d", i), obs_q[i].data, 32'hF0 + (i % NUM_CH));
      if (i > 0) check($sformatf("fair_gap%0d", i), obs_q[i].cyc - obs_q[i-1].cyc, 2);
    end

    // Stats: ch1 completes 17 packets into a 4-bit counter
    do_reset();
    for (int p = 0; p < 3; p++) send_pkt(1, 1, 32'h100 + p, 1'b1);
    stat_sel = 3'd1;
    #1;
`ifdef TREE_NODE_MUX_STATS_EN
    check("stat_cnt_after3", stat_cnt, 3);
`else
    check("stat_cnt_after3", stat_cnt, 0);
`endif
    for (int p = 3; p < 17; p++) send_pkt(1, 1, 32'h100 + p, 1'b1);
    tick();
    stat_sel = 3'd1;
    #1;
`ifdef TREE_NODE_MUX_STATS_EN
    check("stat_cnt_saturated", stat_cnt, 15);
`else
    check("stat_cnt_saturated", stat_cnt, 0);
`endif
    stat_sel = 3'd0;
    #1;
    check("stat_cnt_ch0", stat_cnt, 0);
    stat_sel = 3'd7;
    #1;
    check("stat_cnt_out_of_range", stat_cnt, 0);
    check("stats_beats", obs_q.size(), 17);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/tree_node_mux.md
Name: tree_node_mux

Overview:
- Parametrised N-way hierarchy node.
- Merges NUM_CH child packet streams (valid/ready/last) into one upstream stream. Arbitration is round-robin and the grant is held for a whole packet.
- Fan-in is set by a parameter, so one node type can be instantiated at every level of the generated module tree.
- Output is registered.

Parameters:
- NUM_CH, 5, number of child channels (2..16).
- DATA_W, 32, payload width per beat.
- SRC_W, $clog2(NUM_CH), width of the source-index tag.
- CNT_W, 16, width of the per-channel packet counters (stats feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  NUM_CH  per-child beat valid.
- in_data  in  NUM_CH*DATA_W  per-child payload; channel i occupies bits [i*DATA_W +: DATA_W].
- in_last  in  NUM_CH  per-child end-of-packet.
- in_ready  out  NUM_CH  per-child accept.
- out_valid  out  1  upstream beat valid.
- out_data  out  DATA_W  upstream payload.
- out_last  out  1  upstream end-of-packet.
- out_src  out  SRC_W  index of the child that sourced the beat.
- out_ready  in  1  upstream accept.
- busy  out  1  high while a packet is locked.
- stat_sel  in  SRC_W  counter select.
- stat_cnt  out  CNT_W  selected channel's packet count.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_src=0, in_ready=0, busy=0.
  - State=IDLE; round-robin pointer ptr=0; counters=0.
  - Reset takes priority in any state. A packet in flight is abandoned and the output register is cleared.
- Handshake: a transfer occurs on a rising edge where valid&&ready. Once valid is asserted, data and last are held until the transfer.
- FSM IDLE:
  - If any in_valid is set, grant the first set bit scanning ptr, ptr+1, …, NUM_CH-1, 0, … (wrap).
  - Register grant, set busy=1, go to LOCK.
  - in_ready is all-zero in IDLE. This gives a one-cycle arbitration bubble.
- FSM LOCK:
  - in_ready[grant] = !out_valid || out_ready. All other in_ready bits are 0.
  - On an accepted beat, load the output register with data, last and src=grant, and set out_valid=1.
  - If the accepted beat has last=1:
    - go to IDLE; busy=0;
    - ptr = (grant+1) mod NUM_CH, wrapping NUM_CH-1 → 0.
- Output register:
  - Cleared to out_valid=0 when out_ready && out_valid and no new beat loads in the same cycle.
  - A simultaneous drain and load keeps out_valid=1 with the new beat. Throughput is 1 beat/cycle inside a packet.
- Latency: in_valid rising in IDLE at cycle 0 gives grant at edge 1, accept at edge 2, and out_valid visible after edge 2, i.e. 2 cycles.
- Single-beat packets (last=1 on the first beat): LOCK lasts one accept. Steady-state throughput is then 1 packet per 2 cycles.
- A child dropping in_valid mid-packet: the grant is held and the node waits indefinitely. No other child is served.
- out_ready held low: the output register holds and in_ready[grant]=0. No beat is lost or duplicated.
- No requests: the node stays in IDLE and ptr is unchanged.

Optional Feature:
- Macro: TREE_NODE_MUX_STATS_EN.
- When defined:
  - Each channel has a CNT_W counter that increments on the accepted beat carrying last=1 for that channel.
  - Counters saturate at all-ones and do not wrap.
  - stat_cnt = counter[stat_sel] as a combinational read. A stat_sel ≥ NUM_CH returns 0.
- When undefined: no counters are built; stat_cnt is tied to 0 and stat_sel is ignored. The ports remain present so the interface is identical.

Test Plan:
- Reset mid-packet: ch1 has sent 2 of 4 beats and rst is pulsed → next cycle out_valid=0, busy=0, in_ready=0, ptr=0; a fresh request from ch3 is granted and out_src=3.
- Fairness: all 5 children request continuously with 1-beat packets and out_ready=1 → out_src sequence 0,1,2,3,4,0,… with one packet per 2 cycles.
- Packet lock: ch2 sends a 3-beat packet (data 0xA0,0xA1,0xA2) while ch0 requests → output is 0xA0,0xA1,0xA2 with src=2 and last only on 0xA2, then ch0 is served.
- Backpressure: out_ready toggles 1,0,0,1,… during a 4-beat packet from ch4 → no drop or duplicate; the 4 beats appear in order and in_ready[4] follows the stall.
- Wrap: ptr=4 and ch4 is idle while ch0 and ch3 request → grant=0, next ptr=1.
- Stats (TREE_NODE_MUX_STATS_EN, CNT_W=4): ch1 completes 17 packets → stat_sel=1 gives stat_cnt=15 (saturated); the same run without the macro gives stat_cnt=0.
